// File: rtl/cp0_regfile.sv
// MIPS-style CP0 register subset: Status, Cause, EPC, BadVAddr, Count and Compare.
// Handles MTC0/MFC0 access, exception entry and ERET bookkeeping, and the Count/Compare timer.
module cp0_regfile #(
    parameter logic [31:0] STATUS_RESET = 32'h0040_0000,
    parameter int unsigned TIMER_DIV2   = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [4:0]  raddr_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] except_type_i,
    input  logic [31:0] pc_i,
    input  logic        in_delayslot_i,
    input  logic [31:0] badvaddr_i,
    input  logic [5:0]  ext_int_i,
    output logic [31:0] rdata_o,
    output logic [31:0] status_o,
    output logic [31:0] cause_o,
    output logic [31:0] epc_o,
    output logic [31:0] badvaddr_o,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic        timer_int_o
);
    localparam logic [4:0]  REG_BADVADDR = 5'd8;
    localparam logic [4:0]  REG_COUNT    = 5'd9;
    localparam logic [4:0]  REG_COMPARE  = 5'd11;
    localparam logic [4:0]  REG_STATUS   = 5'd12;
    localparam logic [4:0]  REG_CAUSE    = 5'd13;
    localparam logic [4:0]  REG_EPC      = 5'd14;
    localparam logic [31:0] EXC_ERET     = 32'h0000_000E;
    localparam logic [31:0] EXC_INT      = 32'h0000_0001;
    localparam logic [31:0] EXC_ADEL     = 32'h0000_0004;
    localparam logic [31:0] EXC_ADES     = 32'h0000_0005;

    logic [31:0] status_q, status_d;
    logic [31:0] cause_q, cause_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] badvaddr_q, badvaddr_d;
    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic        tick_q, tick_d;

    logic exc_entry;
    logic eret;
    logic mtc0;
    logic count_adv;

    assign exc_entry = (except_type_i != '0) && (except_type_i != EXC_ERET);
    assign eret      = (except_type_i == EXC_ERET);
    // An MTC0 colliding with exception entry or ERET is dropped entirely.
    assign mtc0      = we_i && !exc_entry && !eret;
    assign count_adv = (TIMER_DIV2 != 0) ? tick_q : 1'b1;

    // NOTE: every _d is given its current value first, so no path through the block leaves it unassigned (no latch).
    always_comb begin
        status_d   = status_q;
        cause_d    = cause_q;
        epc_d      = epc_q;
        badvaddr_d = badvaddr_q;
        compare_d  = compare_q;
        tick_d     = (TIMER_DIV2 != 0) ? ~tick_q : 1'b0;
        count_d    = count_q + {31'd0, count_adv};

        cause_d[15:10] = ext_int_i;
        if ((count_q == compare_q) && (compare_q != '0)) begin
            cause_d[30] = 1'b1;
        end

        if (mtc0) begin
            case (waddr_i)
                REG_COUNT:   count_d = wdata_i;
                REG_COMPARE: begin
                    compare_d   = wdata_i;
                    cause_d[30] = 1'b0;  // clear beats a same-cycle match
                end
                REG_STATUS: begin
                    status_d[15:8] = wdata_i[15:8];
                    status_d[1:0]  = wdata_i[1:0];
                end
                REG_CAUSE:   cause_d[9:8] = wdata_i[9:8];
                REG_EPC:     epc_d = wdata_i;
                default:     ;
            endcase
        end

        if (exc_entry) begin
            cause_d[6:2] = (except_type_i == EXC_INT) ? 5'd0 : except_type_i[4:0];
            status_d[1]  = 1'b1;
            if ((except_type_i == EXC_ADEL) || (except_type_i == EXC_ADES)) begin
                badvaddr_d = badvaddr_i;
            end
            // A nested exception keeps the EPC/BD of the outermost one.
            if (!status_q[1]) begin
                epc_d       = in_delayslot_i ? (pc_i - 32'd4) : pc_i;
                cause_d[31] = in_delayslot_i;
            end
        end else if (eret) begin
            status_d[1] = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            status_q   <= STATUS_RESET;
            cause_q    <= '0;
            epc_q      <= '0;
            badvaddr_q <= '0;
            count_q    <= '0;
            compare_q  <= '0;
            tick_q     <= 1'b0;
        end else begin
            status_q   <= status_d;
            cause_q    <= cause_d;
            epc_q      <= epc_d;
            badvaddr_q <= badvaddr_d;
            count_q    <= count_d;
            compare_q  <= compare_d;
            tick_q     <= tick_d;
        end
    end

    always_comb begin
        rdata_o = '0;
        case (raddr_i)
            REG_BADVADDR: rdata_o = badvaddr_q;
            REG_COUNT:    rdata_o = count_q;
            REG_COMPARE:  rdata_o = compare_q;
            REG_STATUS:   rdata_o = status_q;
            REG_CAUSE:    rdata_o = cause_q;
            REG_EPC:      rdata_o = epc_q;
            default:      rdata_o = '0;
        endcase
    end

    assign status_o    = status_q;
    assign cause_o     = cause_q;
    assign epc_o       = epc_q;
    assign badvaddr_o  = badvaddr_q;
    assign count_o     = count_q;
    assign compare_o   = compare_q;
    assign timer_int_o = cause_q[30];

endmodule
